// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access stage: FSM state encoding and
// default address-map / timeout constants.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mau_state_t;

  localparam logic [31:0] DEFAULT_MEM_BASE = 32'd1024;
  localparam int          DEFAULT_TIMEOUT  = 255;

endpackage

// File: rtl/mem_access_unit_addr_map.sv
// Translates a byte address from the execute stage into a data-memory word
// index: subtract the memory base (mod 2^32) and drop the byte-lane bits.
module mem_addr_map
  import mem_access_unit_pkg::*;
#(
  parameter logic [31:0] MEM_BASE = DEFAULT_MEM_BASE
) (
  input  logic [31:0] byte_addr,
  output logic [31:0] word_addr
);

  logic [31:0] offset;

  assign offset    = byte_addr - MEM_BASE;
  assign word_addr = {2'b00, offset[31:2]};

endmodule

// File: rtl/mem_access_unit.sv
// Memory access pipeline stage. Non-memory instructions pass through with one
// cycle of latency; loads and stores freeze the upstream pipeline, issue a
// single request to data memory, wait for the acknowledge (or give up after
// TIMEOUT cycles) and then present the write-back bundle.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter logic [31:0] MEM_BASE = DEFAULT_MEM_BASE,
  parameter int          TIMEOUT  = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALU_result,
  input  logic [31:0] val_Rm,
  input  logic [3:0]  Dest,
  input  logic        WB_EN,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  output logic        freeze,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] ALU_result_out,
  output logic [31:0] mem_data_out,
  output logic [3:0]  Dest_out,
  output logic        WB_EN_out,
  output logic        MEM_R_EN_out,
  output logic        timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  mau_state_t       state;
  mau_state_t       next_state;
  logic [CNT_W-1:0] wait_cnt;
  logic [31:0]      lat_addr;
  logic [31:0]      lat_data;
  logic [31:0]      rd_data;
  logic [3:0]       lat_dest;
  logic             lat_wb;
  logic             lat_read;
  logic             lat_write;
  logic             mem_en;
  logic             timeout_hit;

  // A combined read+write request is treated as a write only.
  assign mem_en      = MEM_R_EN | MEM_W_EN;
  assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT - 1));
  assign mem_wdata   = lat_data;

  mem_addr_map #(
    .MEM_BASE (MEM_BASE)
  ) u_addr_map (
    .byte_addr (lat_addr),
    .word_addr (mem_addr)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and request/freeze decode from current state and inputs.
  always_comb begin
    next_state = state;
    freeze     = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    case (state)
      IDLE: begin
        if (mem_en) begin
          freeze     = 1'b1;
          next_state = ACCESS;
        end
      end
      ACCESS: begin
        freeze  = 1'b1;
        mem_req = 1'b1;
        mem_we  = lat_write;
        if (mem_ack || timeout_hit) begin
          next_state = DONE;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Request latches, wait counter, read-data capture and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_addr    <= '0;
      lat_data    <= '0;
      lat_dest    <= '0;
      lat_wb      <= 1'b0;
      lat_read    <= 1'b0;
      lat_write   <= 1'b0;
      rd_data     <= '0;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_en) begin
            lat_addr  <= ALU_result;
            lat_data  <= val_Rm;
            lat_dest  <= Dest;
            lat_wb    <= WB_EN;
            lat_read  <= MEM_R_EN & ~MEM_W_EN;
            lat_write <= MEM_W_EN;
            wait_cnt  <= '0;
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            if (lat_read) begin
              rd_data <= mem_rdata;
            end
            wait_cnt <= '0;
          end else if (timeout_hit) begin
            rd_data     <= '0;
            timeout_err <= 1'b1;
            wait_cnt    <= '0;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Write-back bundle: pass-through in IDLE, bubble while an access is
  // pending, latched request results when the access completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      ALU_result_out <= '0;
      mem_data_out   <= '0;
      Dest_out       <= '0;
      WB_EN_out      <= 1'b0;
      MEM_R_EN_out   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_en) begin
            WB_EN_out    <= 1'b0;
            MEM_R_EN_out <= 1'b0;
          end else begin
            ALU_result_out <= ALU_result;
            Dest_out       <= Dest;
            WB_EN_out      <= WB_EN;
            MEM_R_EN_out   <= MEM_R_EN & ~MEM_W_EN;
          end
        end
        DONE: begin
          ALU_result_out <= lat_addr;
          Dest_out       <= lat_dest;
          WB_EN_out      <= lat_wb;
          MEM_R_EN_out   <= lat_read;
          if (lat_read) begin
            mem_data_out <= rd_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios followed by
// randomized instruction streams checked against a transaction-level model
// with a word-addressed memory array.
module tb_mem_access_unit;

  localparam logic [31:0] BASE = 32'd1024;
  localparam int          TMO  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ALU_result;
  logic [31:0] val_Rm;
  logic [3:0]  Dest;
  logic        WB_EN;
  logic        MEM_R_EN;
  logic        MEM_W_EN;
  logic        freeze;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [31:0] ALU_result_out;
  logic [31:0] mem_data_out;
  logic [3:0]  Dest_out;
  logic        WB_EN_out;
  logic        MEM_R_EN_out;
  logic        timeout_err;

  int total = 0;
  int bad   = 0;

  logic [31:0] memModel [logic [31:0]];
  logic        expTimeoutErr;
  logic [31:0] expMemData;

  mem_access_unit #(
    .MEM_BASE (BASE),
    .TIMEOUT  (TMO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ALU_result     (ALU_result),
    .val_Rm         (val_Rm),
    .Dest           (Dest),
    .WB_EN          (WB_EN),
    .MEM_R_EN       (MEM_R_EN),
    .MEM_W_EN       (MEM_W_EN),
    .freeze         (freeze),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_ack        (mem_ack),
    .ALU_result_out (ALU_result_out),
    .mem_data_out   (mem_data_out),
    .Dest_out       (Dest_out),
    .WB_EN_out      (WB_EN_out),
    .MEM_R_EN_out   (MEM_R_EN_out),
    .timeout_err    (timeout_err)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  // Word index of a byte address in data memory, unsigned wrap-around.
  function automatic logic [31:0] wordOf(input logic [31:0] a);
    logic [31:0] diff;
    diff = a - BASE;
    return diff / 32'd4;
  endfunction

  // Presents one instruction with the DUT in IDLE and follows it until the
  // write-back bundle appears. ackAt is the ACCESS cycle on which the memory
  // acknowledges; values above TMO mean the memory never answers.
  task automatic applyStimulus(input logic [31:0] alu, input logic [31:0] rm,
                               input logic [3:0] dst, input logic wb,
                               input logic rEn, input logic wEn, input int ackAt);
    logic        isMem;
    logic        isRead;
    logic        timedOut;
    logic [31:0] w;
    int          frozen;
    int          expFrozen;
    isMem    = rEn | wEn;
    isRead   = rEn & ~wEn;
    timedOut = 1'b0;
    w        = wordOf(alu);
    frozen   = 0;
    ALU_result = alu;
    val_Rm     = rm;
    Dest       = dst;
    WB_EN      = wb;
    MEM_R_EN   = rEn;
    MEM_W_EN   = wEn;
    mem_ack    = 1'b0;
    mem_rdata  = $urandom;
    @(negedge clk);
    checkOutput("idle_freeze", {31'b0, freeze}, {31'b0, isMem});
    checkOutput("idle_req", {31'b0, mem_req}, 32'd0);
    if (freeze) frozen++;
    @(posedge clk); #1;
    if (!isMem) begin
      checkOutput("pass_alu", ALU_result_out, alu);
      checkOutput("pass_dest", {28'b0, Dest_out}, {28'b0, dst});
      checkOutput("pass_wb", {31'b0, WB_EN_out}, {31'b0, wb});
      checkOutput("pass_rd", {31'b0, MEM_R_EN_out}, 32'd0);
      checkOutput("pass_data", mem_data_out, expMemData);
    end else begin
      checkOutput("bubble_wb", {31'b0, WB_EN_out}, 32'd0);
      checkOutput("bubble_rd", {31'b0, MEM_R_EN_out}, 32'd0);
      for (int c = 1; c <= TMO; c++) begin
        mem_ack = (c == ackAt);
        if (mem_ack && isRead) begin
          if (!memModel.exists(w)) memModel[w] = $urandom;
          mem_rdata = memModel[w];
        end else begin
          mem_rdata = $urandom;
        end
        @(negedge clk);
        checkOutput("acc_req", {31'b0, mem_req}, 32'd1);
        checkOutput("acc_freeze", {31'b0, freeze}, 32'd1);
        checkOutput("acc_we", {31'b0, mem_we}, {31'b0, wEn});
        checkOutput("acc_addr", mem_addr, w);
        checkOutput("acc_wb_bubble", {31'b0, WB_EN_out}, 32'd0);
        if (wEn) checkOutput("acc_wdata", mem_wdata, rm);
        if (freeze) frozen++;
        @(posedge clk); #1;
        if (c == ackAt) begin
          if (wEn) memModel[w] = rm;
          break;
        end
        if (c == TMO) timedOut = 1'b1;
      end
      mem_ack   = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
      @(negedge clk);
      checkOutput("done_freeze", {31'b0, freeze}, 32'd0);
      checkOutput("done_req", {31'b0, mem_req}, 32'd0);
      expFrozen = ((ackAt <= TMO) ? ackAt : TMO) + 1;
      checkOutput("freeze_cycles", frozen, expFrozen);
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (timedOut) expTimeoutErr = 1'b1;
      if (isRead) expMemData = timedOut ? 32'd0 : memModel[w];
      checkOutput("wb_alu", ALU_result_out, alu);
      checkOutput("wb_dest", {28'b0, Dest_out}, {28'b0, dst});
      checkOutput("wb_wb", {31'b0, WB_EN_out}, {31'b0, wb});
      checkOutput("wb_rd", {31'b0, MEM_R_EN_out}, {31'b0, isRead});
      checkOutput("wb_data", mem_data_out, expMemData);
    end
    checkOutput("timeout_err", {31'b0, timeout_err}, {31'b0, expTimeoutErr});
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_alu"}, ALU_result_out, 32'd0);
    checkOutput({tag, "_data"}, mem_data_out, 32'd0);
    checkOutput({tag, "_dest"}, {28'b0, Dest_out}, 32'd0);
    checkOutput({tag, "_wb"}, {31'b0, WB_EN_out}, 32'd0);
    checkOutput({tag, "_rd"}, {31'b0, MEM_R_EN_out}, 32'd0);
    checkOutput({tag, "_terr"}, {31'b0, timeout_err}, 32'd0);
    checkOutput({tag, "_req"}, {31'b0, mem_req}, 32'd0);
  endtask

  task automatic clearInputs();
    ALU_result = '0;
    val_Rm     = '0;
    Dest       = '0;
    WB_EN      = 1'b0;
    MEM_R_EN   = 1'b0;
    MEM_W_EN   = 1'b0;
    mem_ack    = 1'b0;
    mem_rdata  = '0;
  endtask

  // Directed scenarios, randomized stream, then reset in the middle of an access.
  initial begin
    int          kind;
    logic [31:0] a;
    expTimeoutErr = 1'b0;
    expMemData    = 32'd0;
    rst = 1'b1;
    clearInputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkAllZero("reset");
    checkOutput("reset_freeze", {31'b0, freeze}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    applyStimulus(32'd5, 32'd0, 4'd3, 1'b1, 1'b0, 1'b0, 1);
    applyStimulus(32'd1032, 32'hDEADBEEF, 4'd0, 1'b0, 1'b0, 1'b1, 3);
    memModel[32'd0] = 32'h12345678;
    applyStimulus(32'd1024, 32'd0, 4'd7, 1'b1, 1'b1, 1'b0, 1);
    applyStimulus(32'd1020, 32'hCAFEF00D, 4'd5, 1'b1, 1'b1, 1'b1, 2);
    applyStimulus(32'd1032, 32'd0, 4'd9, 1'b1, 1'b1, 1'b0, 2);
    applyStimulus(32'd1028, 32'd0, 4'd2, 1'b1, 1'b1, 1'b0, TMO + 5);

    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 6);
      if ($urandom_range(0, 7) == 0) a = $urandom;
      else a = BASE + 32'($urandom_range(0, 7)) * 32'd4 + 32'($urandom_range(0, 3));
      case (kind)
        0, 1: applyStimulus($urandom, $urandom, 4'($urandom_range(0, 15)),
                            1'($urandom_range(0, 1)), 1'b0, 1'b0, 1);
        2, 3: applyStimulus(a, $urandom, 4'($urandom_range(0, 15)),
                            1'b1, 1'b1, 1'b0, $urandom_range(1, TMO + 2));
        4, 5: applyStimulus(a, $urandom, 4'($urandom_range(0, 15)),
                            1'b0, 1'b0, 1'b1, $urandom_range(1, TMO + 2));
        default: applyStimulus(a, $urandom, 4'($urandom_range(0, 15)),
                               1'($urandom_range(0, 1)), 1'b1, 1'b1, $urandom_range(1, TMO + 2));
      endcase
    end

    ALU_result = 32'd1040;
    val_Rm     = 32'd0;
    Dest       = 4'd6;
    WB_EN      = 1'b1;
    MEM_R_EN   = 1'b1;
    MEM_W_EN   = 1'b0;
    mem_ack    = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("rst_pre_req", {31'b0, mem_req}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clearInputs();
    expTimeoutErr = 1'b0;
    expMemData    = 32'd0;
    @(negedge clk);
    checkAllZero("rst_mid");
    checkOutput("rst_mid_freeze", {31'b0, freeze}, 32'd0);
    mem_ack   = 1'b1;
    mem_rdata = 32'hA5A5A5A5;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    checkAllZero("rst_late_ack");
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter MEM_BASE, default 32'd1024, byte address of data memory word 0.
REQ-002 Parameter TIMEOUT, default 255, maximum cycles in ACCESS before forced completion.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 ALU_result, val_Rm  in  32 each  byte address and store data from execute stage.
REQ-006 Dest  in  4; WB_EN, MEM_R_EN, MEM_W_EN  in  1 each  control from execute stage.
REQ-007 freeze  out  1  high = upstream pipeline holds all inputs stable.
REQ-008 mem_req, mem_we  out  1 each; mem_addr, mem_wdata  out  32 each  memory request.
REQ-009 mem_rdata  in  32; mem_ack  in  1  read data and single-cycle completion strobe.
REQ-010 ALU_result_out, mem_data_out  out  32 each; Dest_out  out  4; WB_EN_out, MEM_R_EN_out  out  1 each  registered write-back bundle.
REQ-011 timeout_err  out  1  sticky error flag.

Function
REQ-012 mem_en = MEM_R_EN | MEM_W_EN; MEM_W_EN=1 and MEM_R_EN=1 together is a write; read suppressed, MEM_R_EN_out=0.
REQ-013 FSM states IDLE, ACCESS, DONE; reset state IDLE.
REQ-014 IDLE, mem_en=0: freeze=0; output bundle loads inputs next edge (latency 1); mem_data_out unchanged.
REQ-015 IDLE, mem_en=1: freeze=1; latch address, store data, Dest, WB_EN, read/write type; next state ACCESS; WB_EN_out and MEM_R_EN_out cleared next edge (bubble).
REQ-016 ACCESS: mem_req=1, freeze=1; mem_we=1 for writes; mem_addr = (latched addr - MEM_BASE) >> 2, zero-extended; mem_wdata = latched store data; bundle outputs hold bubble.
REQ-017 ACCESS with mem_ack=1: capture mem_rdata on reads; next state DONE; wait counter cleared.
REQ-018 ACCESS without ack: wait counter increments; on reaching TIMEOUT go DONE, set timeout_err, read data = 32'h0.
REQ-019 DONE: freeze=0, mem_req=0; bundle loads latched Dest/WB_EN/read type and address, mem_data_out = captured read data (unchanged for writes); next state IDLE regardless of inputs.
REQ-020 Access latency with ack on kth ACCESS cycle: freeze high k+1 cycles; bundle valid k+2 edges after presentation.
REQ-021 mem_ack outside ACCESS ignored.
REQ-022 mem_req, mem_we, freeze decoded combinationally from state and inputs only; no combinational path from mem_rdata to any output.
REQ-023 Address arithmetic modulo 2^32; addr below MEM_BASE wraps, no error; low two address bits ignored.

Reset
REQ-024 rst=1: state IDLE, wait counter 0, all bundle outputs 0, timeout_err 0, latched fields 0.
REQ-025 Reset during ACCESS: mem_req low from the cycle after the reset edge; pending access abandoned, no write-back.
REQ-026 timeout_err cleared only by rst.

Structure
REQ-027 Shared package holds FSM state enum (2 bits), default MEM_BASE and TIMEOUT constants.
REQ-028 One sub-module, mem_addr_map: combinational base subtraction and word shift.
REQ-029 Wait counter width = $clog2(TIMEOUT+1).

Verification
REQ-030 ALU_result=5, WB_EN=1, Dest=3, no mem -> next edge ALU_result_out=5, Dest_out=3, WB_EN_out=1, freeze never high.
REQ-031 Store ALU_result=1032, val_Rm=32'hDEADBEEF, ack on 3rd ACCESS cycle -> mem_addr=2, mem_we=1, mem_wdata=DEADBEEF, freeze high 4 cycles, WB_EN_out=0 throughout.
REQ-032 Load ALU_result=1024, Dest=7, mem_rdata=32'h12345678 with ack on 1st ACCESS cycle -> freeze high 2 cycles; then mem_data_out=12345678, MEM_R_EN_out=1, Dest_out=7.
REQ-033 Load, mem_ack never asserted, TIMEOUT=4 -> DONE after 4 ACCESS cycles, timeout_err=1 and stays 1, mem_data_out=0.
REQ-034 rst pulsed during 2nd ACCESS cycle -> next cycle mem_req=0, state IDLE, all outputs 0, later ack ignored.
REQ-035 MEM_R_EN=MEM_W_EN=1, ALU_result=1020 -> mem_we=1, mem_addr=32'h3FFFFFFF, MEM_R_EN_out=0.
